// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock-divider scheduler.
package clk_div_pkg;

  // RUN: no divisor waiting; PEND: a new divisor is held until the next period boundary.
  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } sched_state_e;

  localparam int DIV_MIN = 1;

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter and output toggle for the clock divider.
// clk_out toggles every `div` cycles; `boundary` marks the last cycle of a
// high phase, the only place a new divisor may take effect. `hold` parks the
// counter at 0 with clk_out low.
module clk_div_core #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 hold,
  output logic                 boundary,
  output logic                 clk_out,
  output logic                 rise_stb,
  output logic                 fall_stb
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 clk_out_q, clk_out_d;
  logic                 rise_stb_q, rise_stb_d;
  logic                 fall_stb_q, fall_stb_d;
  logic                 term_cnt;

  assign term_cnt = (cnt_q == (div - DIV_WIDTH'(1)));
  assign boundary = term_cnt && clk_out_q;

  // Next counter/toggle value; strobes follow the edge of clk_out being registered.
  always_comb begin
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    if (hold) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
    end else if (term_cnt) begin
      cnt_d     = '0;
      clk_out_d = ~clk_out_q;
    end else begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
    rise_stb_d = clk_out_d & ~clk_out_q;
    fall_stb_d = ~clk_out_d & clk_out_q;
  end

  // Counter, divided clock and edge strobes.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt_q      <= '0;
      clk_out_q  <= 1'b0;
      rise_stb_q <= 1'b0;
      fall_stb_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      clk_out_q  <= clk_out_d;
      rise_stb_q <= rise_stb_d;
      fall_stb_q <= fall_stb_d;
    end
  end

  assign clk_out  = clk_out_q;
  assign rise_stb = rise_stb_q;
  assign fall_stb = fall_stb_q;

endmodule

// File: rtl/clk_div_scheduler.sv
// Programmable clock divider with glitch-free divisor changes.
// A requested divisor is parked in a pending register and only applied at the
// end of a high phase, so neither phase is ever shortened.
// Optional feature: define CLK_DIV_GATE_EN to add gate_req/gate_ack, which stop
// clk_out low at a period boundary.
//
// state | meaning
// RUN   | no pending divisor, cfg_ready high
// PEND  | divisor held in pend_q, applied at the next period boundary
module clk_div_scheduler
  import clk_div_pkg::*;
#(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 cfg_valid,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  output logic                 cfg_ready,
  output logic                 cfg_err,
  output logic                 cfg_done,
  output logic [DIV_WIDTH-1:0] cur_div,
  output logic                 clk_out,
  output logic                 rise_stb,
  output logic                 fall_stb
`ifdef CLK_DIV_GATE_EN
  ,
  input  logic                 gate_req,
  output logic                 gate_ack
`endif
);

  if ((DEFAULT_DIV < DIV_MIN) || (DEFAULT_DIV > ((2 ** DIV_WIDTH) - 1))) begin : g_bad_default_div
    $error("clk_div_scheduler: DEFAULT_DIV out of range for DIV_WIDTH");
  end

  localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);

  sched_state_e         state_q, state_d;
  logic [DIV_WIDTH-1:0] pend_q, pend_d;
  logic [DIV_WIDTH-1:0] cur_div_q, cur_div_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 cfg_done_q, cfg_done_d;
  logic                 boundary;
  logic                 hold;

  clk_div_core #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_core (
    .clk_in  (clk_in),
    .reset   (reset),
    .div     (cur_div_q),
    .hold    (hold),
    .boundary(boundary),
    .clk_out (clk_out),
    .rise_stb(rise_stb),
    .fall_stb(fall_stb)
  );

  // Request capture in RUN, divisor swap at the boundary in PEND. A request
  // taken in a boundary cycle only reaches PEND afterwards, so it waits a period.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    cur_div_d  = cur_div_q;
    cfg_err_d  = 1'b0;
    cfg_done_d = 1'b0;
    case (state_q)
      RUN: begin
        if (cfg_valid) begin
          if (cfg_div != '0) begin
            pend_d  = cfg_div;
            state_d = PEND;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      PEND: begin
        if (boundary) begin
          cur_div_d  = pend_q;
          pend_d     = '0;
          state_d    = RUN;
          cfg_done_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Scheduler state and registered handshake pulses.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= RUN;
      pend_q     <= '0;
      cur_div_q  <= DEF_DIV;
      cfg_err_q  <= 1'b0;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cur_div_q  <= cur_div_d;
      cfg_err_q  <= cfg_err_d;
      cfg_done_q <= cfg_done_d;
    end
  end

`ifdef CLK_DIV_GATE_EN
  logic stopped_q, stopped_d;

  // Stop only at a boundary so the last high phase is full length; resume on release.
  always_comb begin
    stopped_d = stopped_q;
    if (!stopped_q && boundary && gate_req) begin
      stopped_d = 1'b1;
    end else if (stopped_q && !gate_req) begin
      stopped_d = 1'b0;
    end
  end

  // Gate state register.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      stopped_q <= 1'b0;
    end else begin
      stopped_q <= stopped_d;
    end
  end

  assign hold     = stopped_q;
  assign gate_ack = stopped_q;
`else
  assign hold = 1'b0;
`endif

  assign cfg_ready = (state_q == RUN);
  assign cfg_err   = cfg_err_q;
  assign cfg_done  = cfg_done_q;
  assign cur_div   = cur_div_q;

endmodule
